// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 11 is illegal, so it is reported as a fault like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return low[0];
            SZ_WORD: return (low != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends a byte or halfword for loads
// and merges store data into the word that was read back.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merge_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shamt      = 5'd0;
        mask       = 32'hFFFF_FFFF;
        load_val   = word;
        merge_word = store_data;
        shifted    = word;
        case (size)
            SZ_BYTE: begin
                shamt      = {lane, 3'b000};
                shifted    = word >> shamt;
                mask       = 32'h0000_00FF << shamt;
                load_val   = {{24{sign & shifted[7]}}, shifted[7:0]};
                merge_word = (word & ~mask) | ((store_data & 32'h0000_00FF) << shamt);
            end
            SZ_HALF: begin
                shamt      = {lane[1], 4'b0000};
                shifted    = word >> shamt;
                mask       = 32'h0000_FFFF << shamt;
                load_val   = {{16{sign & shifted[15]}}, shifted[15:0]};
                merge_word = (word & ~mask) | ((store_data & 32'h0000_FFFF) << shamt);
            end
            default: begin
                load_val   = word;
                merge_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-addressed memory underneath,
// sub-word loads extracted and sub-word stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    state_t      next_state;
    logic        lat_we;
    logic        lat_sign;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] load_val;
    logic [31:0] merge_word;
    logic        accept;

    assign accept = (state == IDLE) && req;

    lsu_lane u_lane (
        .word       (mem_rdata),
        .lane       (lat_lane),
        .size       (lat_size),
        .sign       (lat_sign),
        .store_data (lat_wdata),
        .load_val   (load_val),
        .merge_word (merge_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Word stores need no read-back, so they skip READ entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (is_misaligned(size, addr[1:0]))   next_state = FAULT;
                    else if (we && (size == SZ_WORD))     next_state = WRITE;
                    else                                  next_state = READ;
                end
            end
            READ:    next_state = lat_we ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE) || (state == FAULT);
        misalign  = (state == FAULT);
        mem_write = (state == WRITE);
    end

    // mem_wdata doubles as the merge register; rdata only moves on a load or a fault.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_we    <= 1'b0;
            lat_sign  <= 1'b0;
            lat_size  <= 2'b00;
            lat_lane  <= 2'b00;
            lat_wdata <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else if (accept) begin
            lat_we    <= we;
            lat_sign  <= sign;
            lat_size  <= size;
            lat_lane  <= addr[1:0];
            lat_wdata <= wdata;
            mem_addr  <= {addr[31:2], 2'b00};
            if (we && (size == SZ_WORD)) mem_wdata <= wdata;
            if (is_misaligned(size, addr[1:0])) rdata <= 32'd0;
        end else if (state == READ) begin
            if (lat_we) mem_wdata <= merge_word;
            else        rdata     <= load_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a byte-array memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misalign, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [16];
    logic [7:0]  refmem [64];
    logic        preload_en = 1'b0;
    logic [3:0]  preload_idx = 4'd0;
    logic [31:0] preload_data = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clock) begin
        if (preload_en)     mem[preload_idx] <= preload_data;
        else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end

    function automatic logic [31:0] ref_word(input int idx);
        return {refmem[4*idx+3], refmem[4*idx+2], refmem[4*idx+1], refmem[4*idx]};
    endfunction

    // Reference model: byte-addressed memory, spec-level rules for faults, latency and extension.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, output logic fault, output logic [31:0] exp_rd,
                         output int exp_lat, output int exp_writes);
        int n;
        int base;
        logic [31:0] val;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a[5:0]);
        fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        exp_rd = 32'd0;
        exp_writes = 0;
        if (fault) begin
            exp_lat = 1;
        end else if (w) begin
            for (int k = 0; k < n; k++) refmem[base + k] = d[8*k +: 8];
            exp_lat = (n == 4) ? 2 : 3;
            exp_writes = 1;
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++) val[8*k +: 8] = refmem[base + k];
            if (n < 4 && sg && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
            exp_rd = val;
            exp_lat = 2;
        end
    endtask

    // Drives one request, counts edges from accept to done, then steps back to IDLE.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int writes,
                         output logic mis, output logic [31:0] rd, output logic [31:0] madr);
        @(negedge clock);
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = d;
        @(posedge clock); #1;
        req = 1'b0;
        lat = 1;
        writes = 0;
        while (!done && lat < 12) begin
            if (mem_write) writes++;
            @(posedge clock); #1;
            lat++;
        end
        mis = misalign;
        rd = rdata;
        madr = mem_addr;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, misalign, mem_write} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, misalign, mem_write});
        end
        vectors++;
        if ({rdata, mem_addr, mem_wdata} !== 96'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h expected all 0", rdata, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            preload_en = 1'b1;
            preload_idx = 4'(i);
            preload_data = (i == 2) ? 32'h8899_AABB : $urandom;
            for (int k = 0; k < 4; k++) refmem[4*i + k] = preload_data[8*k +: 8];
        end
        @(negedge clock);
        preload_en = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_loads();
        int lat, writes, elat, ewr;
        logic mis, fault;
        logic [31:0] rd, madr, erd;
        logic [31:0] a_list [3] = '{32'h0B, 32'h0A, 32'h08};
        logic [1:0]  s_list [3] = '{2'd0, 2'd1, 2'd1};
        logic        g_list [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] r_list [3] = '{32'hFFFF_FF88, 32'h0000_8899, 32'hFFFF_AABB};
        for (int i = 0; i < 3; i++) begin
            model(1'b0, s_list[i], g_list[i], a_list[i], 32'd0, fault, erd, elat, ewr);
            issue(1'b0, s_list[i], g_list[i], a_list[i], 32'd0, lat, writes, mis, rd, madr);
            vectors++;
            if (rd !== r_list[i] || lat !== 2 || writes !== 0 || mis !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL load_%0d: rdata=%h lat=%0d writes=%0d mis=%b expected rdata=%h lat=2 writes=0 mis=0",
                         i, rd, lat, writes, mis, r_list[i]);
            end
        end
    endtask

    task automatic test_faults();
        int lat, writes, elat, ewr;
        logic mis, fault;
        logic [31:0] rd, madr, erd;
        model(1'b0, 2'd1, 1'b0, 32'h05, 32'd0, fault, erd, elat, ewr);
        issue(1'b0, 2'd1, 1'b0, 32'h05, 32'd0, lat, writes, mis, rd, madr);
        vectors++;
        if (lat !== 1 || mis !== 1'b1 || rd !== 32'd0 || writes !== 0) begin
            miscompares++;
            $display("[TB] FAIL fault_half: lat=%0d mis=%b rdata=%h writes=%0d expected 1 1 0 0", lat, mis, rd, writes);
        end
        model(1'b1, 2'd3, 1'b0, 32'h00, 32'hDEAD_BEEF, fault, erd, elat, ewr);
        issue(1'b1, 2'd3, 1'b0, 32'h00, 32'hDEAD_BEEF, lat, writes, mis, rd, madr);
        vectors++;
        if (lat !== 1 || mis !== 1'b1 || rd !== 32'd0 || writes !== 0 || mem[0] !== ref_word(0)) begin
            miscompares++;
            $display("[TB] FAIL fault_size3: lat=%0d mis=%b rdata=%h writes=%0d mem0=%h expected 1 1 0 0 %h",
                     lat, mis, rd, writes, mem[0], ref_word(0));
        end
    endtask

    task automatic test_reset_during_write();
        int lat, writes, elat, ewr;
        logic mis, fault;
        logic [31:0] rd, madr, erd;
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd0; sign = 1'b0; addr = 32'h08; wdata = 32'h0000_0077;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_write_reach: mem_write got %b expected 1", mem_write);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, misalign, mem_write} !== 4'b0000 || {rdata, mem_addr, mem_wdata} !== 96'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_write_outputs: flags=%b rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
                     {busy, done, misalign, mem_write}, rdata, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        vectors++;
        if (mem[2] !== 32'h8899_AABB) begin
            miscompares++;
            $display("[TB] FAIL rst_write_mem: word 0x08 got %h expected 8899aabb", mem[2]);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, fault, erd, elat, ewr);
        issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, lat, writes, mis, rd, madr);
        vectors++;
        if (rd !== 32'h8899_AABB || lat !== 2) begin
            miscompares++;
            $display("[TB] FAIL rst_write_reload: rdata=%h lat=%0d expected 8899aabb lat=2", rd, lat);
        end
    endtask

    task automatic test_sub_word_store();
        int lat, writes, elat, ewr;
        logic mis, fault;
        logic [31:0] rd, madr, erd;
        model(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_005C, fault, erd, elat, ewr);
        issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_005C, lat, writes, mis, rd, madr);
        vectors++;
        if (mem[2] !== 32'h8899_5CBB || lat !== 3 || writes !== 1 || mis !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL byte_store: word=%h lat=%0d writes=%0d mis=%b expected 88995cbb 3 1 0",
                     mem[2], lat, writes, mis);
        end
    endtask

    task automatic test_word_store_busy();
        int lat, writes, elat, ewr;
        logic fault;
        logic [31:0] erd;
        model(1'b1, 2'd2, 1'b0, 32'h1C, 32'h1234_5678, fault, erd, elat, ewr);
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd2; sign = 1'b0; addr = 32'h1C; wdata = 32'h1234_5678;
        @(posedge clock); #1;
        req = 1'b0;
        vectors++;
        if (mem_write !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL word_store_first: mem_write=%b busy=%b expected 1 1", mem_write, busy);
        end
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h00; wdata = 32'hBAD0_BAD0;
        @(posedge clock); #1;
        req = 1'b0;
        vectors++;
        if (done !== 1'b1 || misalign !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL word_store_done: done=%b misalign=%b expected 1 0 two edges after accept", done, misalign);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        vectors++;
        if (busy !== 1'b0 || mem[7] !== 32'h1234_5678 || mem[0] !== ref_word(0)) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore: busy=%b word7=%h word0=%h expected 0 12345678 %h",
                     busy, mem[7], mem[0], ref_word(0));
        end
    endtask

    task automatic test_back_to_back();
        int k, elat, ewr;
        logic fault;
        logic [31:0] erd1, erd2;
        model(1'b0, 2'd2, 1'b0, 32'h1C, 32'd0, fault, erd1, elat, ewr);
        model(1'b0, 2'd0, 1'b1, 32'h0B, 32'd0, fault, erd2, elat, ewr);
        @(negedge clock);
        req = 1'b1; we = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h1C;
        @(posedge clock); #1;
        k = 1;
        while (!done && k < 12) begin
            @(posedge clock); #1;
            k++;
        end
        vectors++;
        if (k !== 2 || rdata !== erd1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: lat=%0d rdata=%h expected 2 %h", k, rdata, erd1);
        end
        size = 2'd0; sign = 1'b1; addr = 32'h0B;
        @(posedge clock); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_gap: busy=%b expected 0", busy);
        end
        k = 0;
        while (!done && k < 12) begin
            @(posedge clock); #1;
            k++;
        end
        req = 1'b0;
        vectors++;
        if (k !== 2 || rdata !== erd2) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: edges=%0d rdata=%h expected 2 %h", k, rdata, erd2);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        int lat, writes, elat, ewr;
        logic mis, fault, w, sg;
        logic [1:0] sz;
        logic [31:0] rd, madr, erd, a, d;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 63));
            d  = $urandom;
            model(w, sz, sg, a, d, fault, erd, elat, ewr);
            issue(w, sz, sg, a, d, lat, writes, mis, rd, madr);
            vectors++;
            if (lat !== elat || writes !== ewr || mis !== fault) begin
                miscompares++;
                $display("[TB] FAIL rand_%0d_ctrl: lat=%0d writes=%0d mis=%b expected %0d %0d %b (we=%b size=%0d addr=%h)",
                         i, lat, writes, mis, elat, ewr, fault, w, sz, a);
            end
            if (!w || fault) begin
                vectors++;
                if (rd !== erd) begin
                    miscompares++;
                    $display("[TB] FAIL rand_%0d_rdata: got %h expected %h (size=%0d sign=%b addr=%h)",
                             i, rd, erd, sz, sg, a);
                end
            end
            if (!fault) begin
                vectors++;
                if (madr !== {a[31:2], 2'b00} || mem[a[5:2]] !== ref_word(int'(a[5:2]))) begin
                    miscompares++;
                    $display("[TB] FAIL rand_%0d_mem: mem_addr=%h word=%h expected %h %h",
                             i, madr, mem[a[5:2]], {a[31:2], 2'b00}, ref_word(int'(a[5:2])));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_faults();
        test_reset_during_write();
        test_sub_word_store();
        test_word_store_busy();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
